ufifo_ext: RTL and testbench
============================

Name: ufifo_ext

Overview:
Parametrised successor to the UART byte FIFO. It is a synchronous show-ahead FIFO that uses every entry (2^LGFLEN usable), with:
- runtime-programmable almost-full and almost-empty thresholds;
- synchronous flush;
- sticky overflow and underflow flags;
- a full-width fill count.

It sits between the bus and the UART TX/RX cores. RXFIFO selects whether the status word reports fill or free space.

Parameters:
- BW, 8: data width in bits, 1..32.
- LGFLEN, 4: log2 depth, legal 2..9; FLEN = 2^LGFLEN usable entries.
- RXFIFO, 1: 1 = status reports entries to read; 0 = status reports free slots.

Ports:
- i_clk  in  1  clock, all logic on rising edge.
- i_reset_n  in  1  synchronous active-low reset.
- i_wr  in  1  write request.
- i_data  in  BW  write data.
- i_rd  in  1  read/pop request.
- o_data  out  BW  head entry, valid while o_empty_n.
- o_empty_n  out  1  FIFO holds >=1 entry.
- o_full  out  1  FIFO holds FLEN entries.
- i_flush  in  1  discard all contents.
- i_afull_thresh  in  LGFLEN+1  almost-full threshold.
- i_aempty_thresh  in  LGFLEN+1  almost-empty threshold.
- o_afull  out  1  fill >= i_afull_thresh.
- o_aempty  out  1  fill <= i_aempty_thresh.
- o_fill  out  LGFLEN+1  current entry count, 0..FLEN.
- o_err  out  1  combinational pulse, write rejected this cycle.
- o_ovf  out  1  sticky overflow.
- o_udf  out  1  sticky underflow.
- i_clr_err  in  1  clears o_ovf/o_udf.
- o_status  out  16  {lglen[3:0], cnt[9:0], half, avail}.

Behaviour:
- Reset (i_reset_n=0 at clock edge): pointers and count go to 0. Outputs after reset:
  - o_empty_n=0, o_full=0, o_fill=0, o_ovf=0, o_udf=0, o_afull=(i_afull_thresh==0).
  - o_aempty=1.
  - o_data is don't-care.
  - Storage RAM is not reset.
  - Reset mid-operation discards contents; the next cycle behaves as empty.
- Pointers are LGFLEN+1 bits. Full when MSBs differ and the low bits match. Empty when the pointers are equal. Wrap is natural modulo 2^(LGFLEN+1).
- Read accept: w_read = i_rd && o_empty_n && !i_flush.
- Write accept: w_write = i_wr && !i_flush && (!o_full || w_read). When full, a simultaneous read and write is accepted and the count is unchanged.
- Write into empty FIFO: o_empty_n=1 and o_data=i_data on the next cycle, i.e. 1-cycle latency via a bypass register. A read in that same cycle is ignored, because the FIFO was empty.
- Pop: o_data presents the next entry on the cycle after w_read, with no bubble. Back-to-back pops at full rate are supported.
- Simultaneous write and read with 1 entry: the new entry becomes the head next cycle, o_empty_n stays 1, count stays 1.
- o_fill is registered: +1 on write only, -1 on read only, unchanged on both or neither.
- o_full and o_empty_n are registered and consistent with o_fill (o_full == (o_fill==FLEN); o_empty_n == (o_fill!=0)).
- o_afull and o_aempty are registered, computed from the next-state fill and the current threshold inputs. A threshold change takes effect on the next cycle.
- o_err = i_wr && !w_write && !i_flush.
- o_ovf: set on o_err.
- o_udf: set on i_rd && !o_empty_n && !i_flush.
- Sticky-flag priority: set beats i_clr_err when both happen in the same cycle. Flags are held until cleared or reset.
- Flush: i_flush=1 empties the FIFO next cycle (same state as reset, sticky flags excepted, which are kept). It overrides i_wr and i_rd that cycle, with no error raised.
- o_status:
  - lglen = LGFLEN.
  - cnt = o_fill (RXFIFO=1) or FLEN-o_fill (RXFIFO=0), zero-extended to 10 bits.
  - half = cnt >= FLEN/2.
  - avail = o_empty_n (RXFIFO=1) or !o_full (RXFIFO=0).

Test Plan:
- Reset, then write 0xA5 once → next cycle o_empty_n=1, o_data=0xA5, o_fill=1, o_aempty=1 with thresh 1. Pop → o_empty_n=0 the cycle after.
- LGFLEN=4: write 0x00..0x0F with no reads → o_full=1, o_fill=16, status cnt=16, half=1. 17th write → o_err=1 that cycle, o_ovf=1 sticky, contents unchanged. Drain → 0x00..0x0F in order.
- Full FIFO, i_wr=i_rd=1 for 20 cycles with incrementing data → no o_err, o_fill stays 16, output order preserved across pointer wrap.
- i_afull_thresh=12, i_aempty_thresh=3: fill 0→16→0 → o_afull rises the cycle after fill reaches 12 and falls after fill drops to 11. o_aempty is 1 for fill<=3.
- 9 entries, i_flush with i_wr=i_rd=1 → next cycle o_fill=0, o_empty_n=0, o_err=0. Pre-set o_ovf stays 1. i_clr_err → o_ovf=0.
- Pop on empty → o_udf=1, o_fill stays 0. RXFIFO=0 after 5 writes → status cnt=11, avail=1. Assert i_reset_n=0 mid-burst → all counts and flags 0 next cycle.

Source files
------------

// File: rtl/ufifo_ext.sv
// Show-ahead byte FIFO for the UART path: full 2^LGFLEN depth, programmable
// almost-full/almost-empty thresholds, flush, sticky overflow/underflow flags.
module ufifo_ext #(
    parameter int unsigned BW     = 8,
    parameter int unsigned LGFLEN = 4,
    parameter int unsigned RXFIFO = 1
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_wr,
    input  logic [BW-1:0]     i_data,
    input  logic              i_rd,
    output logic [BW-1:0]     o_data,
    output logic              o_empty_n,
    output logic              o_full,
    input  logic              i_flush,
    input  logic [LGFLEN:0]   i_afull_thresh,
    input  logic [LGFLEN:0]   i_aempty_thresh,
    output logic              o_afull,
    output logic              o_aempty,
    output logic [LGFLEN:0]   o_fill,
    output logic              o_err,
    output logic              o_ovf,
    output logic              o_udf,
    input  logic              i_clr_err,
    output logic [15:0]       o_status
);

    localparam int unsigned FLEN = 1 << LGFLEN;
    localparam logic [LGFLEN:0] FillMax = {1'b1, {LGFLEN{1'b0}}};
    localparam logic [9:0] HalfCnt = 10'(FLEN / 2);

    logic [BW-1:0]   r_mem [FLEN];
    logic [BW-1:0]   r_ram_data;
    logic [BW-1:0]   r_byp_data;
    logic            r_byp_valid;

    logic [LGFLEN:0] r_wr_ptr;
    logic [LGFLEN:0] r_rd_ptr;
    logic [LGFLEN:0] r_fill;
    logic            r_empty_n;
    logic            r_full;
    logic            r_afull;
    logic            r_aempty;
    logic            r_ovf;
    logic            r_udf;

    logic            w_read;
    logic            w_write;
    logic            w_udf_set;
    logic [LGFLEN:0] w_wr_ptr_next;
    logic [LGFLEN:0] w_rd_ptr_next;
    logic [LGFLEN:0] w_fill_next;
    logic            w_full_next;
    logic            w_empty_n_next;
    logic [LGFLEN:0] w_cnt_raw;
    logic [9:0]      w_cnt;
    logic            w_half;
    logic            w_avail;

    assign w_read    = i_rd && r_empty_n && !i_flush;
    assign w_write   = i_wr && !i_flush && (!r_full || w_read);
    assign o_err     = i_wr && !w_write && !i_flush;
    assign w_udf_set = i_rd && !r_empty_n && !i_flush;

    always_comb begin
        w_wr_ptr_next = r_wr_ptr;
        w_rd_ptr_next = r_rd_ptr;
        w_fill_next   = r_fill;
        if (i_flush) begin
            w_wr_ptr_next = '0;
            w_rd_ptr_next = '0;
            w_fill_next   = '0;
        end else begin
            if (w_write) begin
                w_wr_ptr_next = r_wr_ptr + 1'b1;
            end
            if (w_read) begin
                w_rd_ptr_next = r_rd_ptr + 1'b1;
            end
            unique case ({w_write, w_read})
                2'b10:   w_fill_next = r_fill + 1'b1;
                2'b01:   w_fill_next = r_fill - 1'b1;
                default: w_fill_next = r_fill;
            endcase
        end
    end

    // Full: same slot, opposite lap. Empty: identical pointers.
    assign w_full_next = (w_wr_ptr_next[LGFLEN] != w_rd_ptr_next[LGFLEN])
                      && (w_wr_ptr_next[LGFLEN-1:0] == w_rd_ptr_next[LGFLEN-1:0]);
    assign w_empty_n_next = (w_wr_ptr_next != w_rd_ptr_next);

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_fill      <= '0;
            r_empty_n   <= 1'b0;
            r_full      <= 1'b0;
            r_afull     <= (i_afull_thresh == '0);
            r_aempty    <= 1'b1;
            r_byp_valid <= 1'b0;
        end else begin
            r_wr_ptr    <= w_wr_ptr_next;
            r_rd_ptr    <= w_rd_ptr_next;
            r_fill      <= w_fill_next;
            r_empty_n   <= w_empty_n_next;
            r_full      <= w_full_next;
            r_afull     <= (w_fill_next >= i_afull_thresh);
            r_aempty    <= (w_fill_next <= i_aempty_thresh);
            // The entry being written becomes the head next cycle; the RAM
            // read port cannot see it yet, so present it from the bypass.
            r_byp_valid <= w_write && (r_wr_ptr == w_rd_ptr_next);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (o_err) begin
                r_ovf <= 1'b1;
            end else if (i_clr_err) begin
                r_ovf <= 1'b0;
            end
            if (w_udf_set) begin
                r_udf <= 1'b1;
            end else if (i_clr_err) begin
                r_udf <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_write) begin
            r_mem[r_wr_ptr[LGFLEN-1:0]] <= i_data;
        end
        r_ram_data <= r_mem[w_rd_ptr_next[LGFLEN-1:0]];
        r_byp_data <= i_data;
    end

    assign o_data    = r_byp_valid ? r_byp_data : r_ram_data;
    assign o_empty_n = r_empty_n;
    assign o_full    = r_full;
    assign o_fill    = r_fill;
    assign o_afull   = r_afull;
    assign o_aempty  = r_aempty;
    assign o_ovf     = r_ovf;
    assign o_udf     = r_udf;

    always_comb begin
        w_cnt_raw = '0;
        w_avail   = 1'b0;
        if (RXFIFO != 0) begin
            w_cnt_raw = r_fill;
            w_avail   = r_empty_n;
        end else begin
            w_cnt_raw = FillMax - r_fill;
            w_avail   = !r_full;
        end
    end

    assign w_cnt    = 10'(w_cnt_raw);
    assign w_half   = (w_cnt >= HalfCnt);
    assign o_status = {4'(LGFLEN), w_cnt, w_half, w_avail};

endmodule

// File: tb/tb_ufifo_ext.sv
// Randomised and directed bench for ufifo_ext, checked against a queue-based model.
module tb_ufifo_ext;

    localparam int Flen = 16;

    logic       clk = 1'b0;
    logic       i_reset_n, i_wr, i_rd, i_flush, i_clr_err;
    logic [7:0] i_data;
    logic [4:0] i_afull_thresh, i_aempty_thresh;
    logic [7:0] o_data, o_data0;
    logic       o_empty_n, o_full, o_afull, o_aempty, o_err, o_ovf, o_udf;
    logic       o_empty_n0, o_full0, o_afull0, o_aempty0, o_err0, o_ovf0, o_udf0;
    logic [4:0] o_fill, o_fill0;
    logic [15:0] o_status, o_status0;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] q[$];
    bit m_ovf, m_udf, m_afull, m_aempty;
    bit exp_err, obs_err;

    always #5 clk = ~clk;

    ufifo_ext #(.BW(8), .LGFLEN(4), .RXFIFO(1)) dut (
        .i_clk(clk), .i_reset_n(i_reset_n), .i_wr(i_wr), .i_data(i_data), .i_rd(i_rd),
        .o_data(o_data), .o_empty_n(o_empty_n), .o_full(o_full), .i_flush(i_flush),
        .i_afull_thresh(i_afull_thresh), .i_aempty_thresh(i_aempty_thresh),
        .o_afull(o_afull), .o_aempty(o_aempty), .o_fill(o_fill), .o_err(o_err),
        .o_ovf(o_ovf), .o_udf(o_udf), .i_clr_err(i_clr_err), .o_status(o_status)
    );

    ufifo_ext #(.BW(8), .LGFLEN(4), .RXFIFO(0)) dut0 (
        .i_clk(clk), .i_reset_n(i_reset_n), .i_wr(i_wr), .i_data(i_data), .i_rd(i_rd),
        .o_data(o_data0), .o_empty_n(o_empty_n0), .o_full(o_full0), .i_flush(i_flush),
        .i_afull_thresh(i_afull_thresh), .i_aempty_thresh(i_aempty_thresh),
        .o_afull(o_afull0), .o_aempty(o_aempty0), .o_fill(o_fill0), .o_err(o_err0),
        .o_ovf(o_ovf0), .o_udf(o_udf0), .i_clr_err(i_clr_err), .o_status(o_status0)
    );

    // Applies one cycle of stimulus and advances the model past the clock edge.
    task automatic step(input logic wr, input logic [7:0] d, input logic rd,
                        input logic fl, input logic clr, input logic rst);
        int sz;
        bit rd_ok, wr_ok;
        @(negedge clk);
        i_wr = wr; i_data = d; i_rd = rd; i_flush = fl; i_clr_err = clr; i_reset_n = rst;
        #1;
        sz = q.size();
        rd_ok = rd && (sz > 0) && !fl;
        wr_ok = wr && !fl && ((sz < Flen) || rd_ok);
        exp_err = wr && !wr_ok && !fl;
        obs_err = o_err;
        @(posedge clk);
        if (!rst) begin
            q.delete();
            m_ovf = 0;
            m_udf = 0;
        end else begin
            if (clr) begin
                m_ovf = 0;
                m_udf = 0;
            end
            if (exp_err) m_ovf = 1;
            if (rd && sz == 0 && !fl) m_udf = 1;
            if (fl) q.delete();
            else begin
                if (rd_ok) void'(q.pop_front());
                if (wr_ok) q.push_back(d);
            end
        end
        m_afull  = q.size() >= int'(i_afull_thresh);
        m_aempty = q.size() <= int'(i_aempty_thresh);
        #1;
    endtask

    task automatic test_reset();
        i_afull_thresh = 5'd0;
        i_aempty_thresh = 5'd1;
        step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (o_empty_n !== 1'b0 || o_full !== 1'b0 || o_fill !== 5'd0) begin
            errors++;
            $display("FAIL reset_state: empty_n=%b full=%b fill=%0d want 0 0 0",
                     o_empty_n, o_full, o_fill);
        end
        checks++;
        if (o_ovf !== 1'b0 || o_udf !== 1'b0 || o_aempty !== 1'b1 || o_afull !== 1'b1) begin
            errors++;
            $display("FAIL reset_flags: ovf=%b udf=%b aempty=%b afull=%b want 0 0 1 1",
                     o_ovf, o_udf, o_aempty, o_afull);
        end
        i_afull_thresh = 5'd12;
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (o_afull !== 1'b0) begin
            errors++;
            $display("FAIL reset_afull_thresh12: got %b want 0", o_afull);
        end
    endtask

    task automatic test_single();
        step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (o_empty_n !== 1'b1 || o_data !== 8'hA5 || o_fill !== 5'd1 || o_aempty !== 1'b1)
        begin
            errors++;
            $display("FAIL single_write: empty_n=%b data=%h fill=%0d aempty=%b want 1 a5 1 1",
                     o_empty_n, o_data, o_fill, o_aempty);
        end
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
        checks++;
        if (o_empty_n !== 1'b0 || o_fill !== 5'd0) begin
            errors++;
            $display("FAIL single_pop: empty_n=%b fill=%0d want 0 0", o_empty_n, o_fill);
        end
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < Flen; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (o_full !== 1'b1 || o_fill !== 5'd16 || o_status !== {4'd4, 10'd16, 1'b1, 1'b1})
        begin
            errors++;
            $display("FAIL fill_full: full=%b fill=%0d status=%h want 1 16 %h",
                     o_full, o_fill, o_status, {4'd4, 10'd16, 1'b1, 1'b1});
        end
        step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (obs_err !== 1'b1 || o_ovf !== 1'b1 || o_fill !== 5'd16) begin
            errors++;
            $display("FAIL overflow: err=%b ovf=%b fill=%0d want 1 1 16", obs_err, o_ovf, o_fill);
        end
        for (int i = 0; i < Flen; i++) begin
            checks++;
            if (o_data !== 8'(i)) begin
                errors++;
                $display("FAIL drain_order[%0d]: got %h want %h", i, o_data, 8'(i));
            end
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
        end
        checks++;
        if (o_empty_n !== 1'b0 || o_ovf !== 1'b1) begin
            errors++;
            $display("FAIL drain_end: empty_n=%b ovf=%b want 0 1", o_empty_n, o_ovf);
        end
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_full_rw();
        for (int i = 0; i < Flen; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 8'(8'h20 + i), 1'b1, 1'b0, 1'b0, 1'b1);
            checks++;
            if (obs_err !== 1'b0 || o_fill !== 5'd16 || o_data !== 8'(8'h11 + i)) begin
                errors++;
                $display("FAIL full_rw[%0d]: err=%b fill=%0d data=%h want 0 16 %h",
                         i, obs_err, o_fill, o_data, 8'(8'h11 + i));
            end
        end
        for (int i = 0; i < Flen; i++) begin
            checks++;
            if (o_data !== 8'(8'h24 + i)) begin
                errors++;
                $display("FAIL full_rw_drain[%0d]: got %h want %h", i, o_data, 8'(8'h24 + i));
            end
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
        end
    endtask

    task automatic test_thresholds();
        i_afull_thresh = 5'd12;
        i_aempty_thresh = 5'd3;
        for (int i = 0; i < Flen; i++) begin
            step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0, 1'b1);
            checks++;
            if (o_afull !== (i + 1 >= 12) || o_aempty !== (i + 1 <= 3)) begin
                errors++;
                $display("FAIL thresh_up fill=%0d: afull=%b aempty=%b want %b %b",
                         i + 1, o_afull, o_aempty, (i + 1 >= 12), (i + 1 <= 3));
            end
        end
        for (int i = 0; i < Flen; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
            checks++;
            if (o_afull !== (15 - i >= 12) || o_aempty !== (15 - i <= 3)) begin
                errors++;
                $display("FAIL thresh_down fill=%0d: afull=%b aempty=%b want %b %b",
                         15 - i, o_afull, o_aempty, (15 - i >= 12), (15 - i <= 3));
            end
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < Flen + 1; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
        checks++;
        if (o_fill !== 5'd9 || o_ovf !== 1'b1) begin
            errors++;
            $display("FAIL flush_setup: fill=%0d ovf=%b want 9 1", o_fill, o_ovf);
        end
        step(1'b1, 8'h77, 1'b1, 1'b1, 1'b0, 1'b1);
        checks++;
        if (obs_err !== 1'b0 || o_fill !== 5'd0 || o_empty_n !== 1'b0 || o_ovf !== 1'b1) begin
            errors++;
            $display("FAIL flush: err=%b fill=%0d empty_n=%b ovf=%b want 0 0 0 1",
                     obs_err, o_fill, o_empty_n, o_ovf);
        end
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (o_ovf !== 1'b0) begin
            errors++;
            $display("FAIL clr_err_ovf: got %b want 0", o_ovf);
        end
    endtask

    task automatic test_underflow();
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
        checks++;
        if (o_udf !== 1'b1 || o_fill !== 5'd0) begin
            errors++;
            $display("FAIL underflow: udf=%b fill=%0d want 1 0", o_udf, o_fill);
        end
        // Set and clear in the same cycle: set must win.
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
        checks++;
        if (o_udf !== 1'b1) begin
            errors++;
            $display("FAIL udf_set_beats_clr: got %b want 1", o_udf);
        end
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (o_udf !== 1'b0) begin
            errors++;
            $display("FAIL clr_err_udf: got %b want 0", o_udf);
        end
    endtask

    task automatic test_rxfifo0();
        for (int i = 0; i < 5; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (o_status0 !== {4'd4, 10'd11, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL status_tx: got %h want %h", o_status0, {4'd4, 10'd11, 1'b1, 1'b1});
        end
        checks++;
        if (o_status !== {4'd4, 10'd5, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL status_rx: got %h want %h", o_status, {4'd4, 10'd5, 1'b0, 1'b1});
        end
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        bit wr, rd, fl, clr;
        for (int n = 0; n < 600; n++) begin
            if (n % 50 == 0) begin
                i_afull_thresh = 5'($urandom_range(0, 17));
                i_aempty_thresh = 5'($urandom_range(0, 17));
            end
            wr  = ($urandom_range(0, 99) < ((n % 200) < 100 ? 70 : 35));
            rd  = ($urandom_range(0, 99) < ((n % 200) < 100 ? 35 : 70));
            fl  = ($urandom_range(0, 63) == 0);
            clr = ($urandom_range(0, 15) == 0);
            step(wr, 8'($urandom), rd, fl, clr, 1'b1);
            checks++;
            if (o_fill !== 5'(q.size()) || o_empty_n !== (q.size() != 0)
                || o_full !== (q.size() == Flen)) begin
                errors++;
                $display("FAIL rand_count[%0d]: fill=%0d empty_n=%b full=%b want %0d",
                         n, o_fill, o_empty_n, o_full, q.size());
            end
            checks++;
            if (q.size() != 0 && o_data !== q[0]) begin
                errors++;
                $display("FAIL rand_data[%0d]: got %h want %h", n, o_data, q[0]);
            end
            checks++;
            if (obs_err !== exp_err || o_ovf !== m_ovf || o_udf !== m_udf) begin
                errors++;
                $display("FAIL rand_flags[%0d]: err=%b ovf=%b udf=%b want %b %b %b",
                         n, obs_err, o_ovf, o_udf, exp_err, m_ovf, m_udf);
            end
            checks++;
            if (o_afull !== m_afull || o_aempty !== m_aempty) begin
                errors++;
                $display("FAIL rand_thresh[%0d]: afull=%b aempty=%b want %b %b",
                         n, o_afull, o_aempty, m_afull, m_aempty);
            end
            checks++;
            if (o_status0[15:2] !== {4'd4, 10'(Flen - q.size())}
                || o_status0[0] !== (q.size() != Flen)
                || o_status[11:2] !== 10'(q.size())) begin
                errors++;
                $display("FAIL rand_status[%0d]: rx=%h tx=%h fill_model=%0d",
                         n, o_status, o_status0, q.size());
            end
        end
    endtask

    task automatic test_reset_mid();
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'h99, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (o_fill !== 5'd0 || o_empty_n !== 1'b0 || o_full !== 1'b0
            || o_ovf !== 1'b0 || o_udf !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: fill=%0d empty_n=%b full=%b ovf=%b udf=%b want all 0",
                     o_fill, o_empty_n, o_full, o_ovf, o_udf);
        end
        step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (o_fill !== 5'd1 || o_data !== 8'h3C) begin
            errors++;
            $display("FAIL after_reset_write: fill=%0d data=%h want 1 3c", o_fill, o_data);
        end
    endtask

    initial begin
        i_reset_n = 1'b0; i_wr = 1'b0; i_rd = 1'b0; i_flush = 1'b0; i_clr_err = 1'b0;
        i_data = 8'h00; i_afull_thresh = 5'd0; i_aempty_thresh = 5'd1;
        test_reset();
        test_single();
        test_fill_overflow();
        test_full_rw();
        test_thresholds();
        test_flush();
        test_underflow();
        test_rxfifo0();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
